dividend_reconstructor: RTL and testbench
=========================================

Name: dividend_reconstructor

Overview:
- Inverse of the long-division unit: takes a quotient, divisor and remainder and rebuilds dividend = quotient × divisor + remainder.
- Uses a sequential shift-and-add multiplier followed by one remainder add.
- Used in the divider's self-check path and as the stimulus generator for divider regressions.
- Uses the same start/done/error handshake as the divider, so both share one bench harness.

Parameters:
- WIDTH, 8, bit width of quotient, divisor, remainder and dividend.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE; when high, the operands are latched.
- quotient  input  WIDTH  multiplier operand.
- divisor  input  WIDTH  multiplicand operand.
- remainder  input  WIDTH  addend; must be strictly less than divisor.
- dividend  output  WIDTH  registered result. Valid when done=1 and held until the next accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- error  output  1  qualified by done; 1 = invalid operands or overflow.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state goes to IDLE.
  - dividend=0, busy=0, done=0, error=0.
  - All internal registers are cleared.
  - Reset overrides everything, including mid-operation; any in-flight result is discarded.
- Internal registers:
  - acc, 2*WIDTH bits.
  - mcand, 2*WIDTH bits (divisor, zero-extended).
  - mplier, WIDTH bits.
  - rem_r, WIDTH bits.
  - cnt, clog2(WIDTH)+1 bits.
  - ovf, 1 bit.
- States:
  - IDLE: when start=1, latch mplier←quotient, mcand←divisor, rem_r←remainder; set acc←0, cnt←WIDTH, dividend←0; go to CHECK. When start=0, stay.
  - CHECK: if mcand==0, or rem_r ≥ mcand[WIDTH-1:0], go to ERROR. Otherwise go to MULT.
  - MULT, one iteration per cycle:
    - if mplier[0]=1, acc←acc+mcand.
    - mcand←mcand<<1, mplier←mplier>>1, cnt←cnt−1.
    - When the cycle with cnt==1 completes, go to ADD_REM. Exactly WIDTH MULT cycles occur, regardless of operand value; there is no early exit.
  - ADD_REM:
    - acc←acc+rem_r.
    - ovf is computed as (upper WIDTH bits of the new acc ≠ 0).
    - dividend←new acc[WIDTH-1:0] if ovf=0, else 0.
    - Go to RESULT.
  - RESULT: done=1, error=ovf; go to IDLE.
  - ERROR: done=1, error=1, dividend held at 0; go to IDLE.
- Timing:
  - done and error are decoded combinationally from the state and the ovf register.
  - error=0 whenever done=0.
- Latency, with start sampled at edge 0:
  - Valid path: done is high in cycle WIDTH+3 (cycle 11 for WIDTH=8).
  - Invalid-operand path: done is high in cycle 2.
- Start handling:
  - start is ignored while busy=1; it is neither queued nor causes an abort.
  - start=1 in the RESULT or ERROR cycle is ignored. A new start is accepted the cycle after done.
  - Holding start=1 continuously re-launches the operation every WIDTH+4 cycles using fresh operands.
- Arithmetic:
  - All additions are unsigned and 2*WIDTH wide; no carry is lost internally.
  - Overflow is detected only in ADD_REM.
  - Maximum legal result is 2^WIDTH − 1.
  - Operand inputs may change freely after the start cycle.

Test Plan:
- WIDTH=8, quotient=13, divisor=7, remainder=5, start pulse: busy high; done=1, error=0, dividend=96 in cycle 11; busy=0 in cycle 12.
- divisor=0, quotient=4, remainder=0: done=1, error=1, dividend=0 in cycle 2; no MULT cycles occur.
- quotient=3, divisor=7, remainder=7 (remainder ≥ divisor): error=1 at cycle 2. Repeat with remainder=6: dividend=27, error=0.
- Boundaries:
  - quotient=255, divisor=1, remainder=0: dividend=255, error=0.
  - quotient=255, divisor=2, remainder=1 (result 511): error=1, dividend=0.
  - quotient=0, divisor=9, remainder=3: dividend=3.
- Start 13/7/5; assert reset at cycle 5 (mid-MULT): busy=0, done=0, dividend=0 the next cycle. Then start 10/10/9: dividend=109 in cycle 11 after that start.
- Re-pulse start with different operands at cycles 3 and 10 of a 13/7/5 run: ignored; dividend=96. A start in the cycle after done is accepted.

Source files
------------

// File: rtl/dividend_reconstructor.sv
// Rebuilds dividend = quotient * divisor + remainder with a
// shift-and-add multiplier, sharing the divider's start/done/error handshake.
module dividend_reconstructor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] quotient,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] dividend,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MULT,
    S_ADD_REM,
    S_RESULT,
    S_ERROR
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dividend_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;

  logic [AW-1:0]    acc_mult_d;
  logic [AW-1:0]    acc_rem_d;
  logic             ovf_d;
  logic             invalid_d;

  always_comb begin
    acc_mult_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
    acc_rem_d  = acc_q + {{WIDTH{1'b0}}, rem_q};
    ovf_d      = |acc_rem_d[AW-1:WIDTH];
    invalid_d  = (mcand_q == '0) ||
                 (rem_q >= mcand_q[WIDTH-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      dividend_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mplier_q   <= quotient;
            mcand_q    <= {{WIDTH{1'b0}}, divisor};
            rem_q      <= remainder;
            acc_q      <= '0;
            cnt_q      <= CW'(WIDTH);
            dividend_q <= '0;
            ovf_q      <= 1'b0;
            state_q    <= S_CHECK;
          end
        end
        S_CHECK: begin
          state_q <= invalid_d ? S_ERROR : S_MULT;
        end
        // fixed WIDTH iterations, no early exit on a zero multiplier
        S_MULT: begin
          acc_q    <= acc_mult_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_ADD_REM;
          end
        end
        S_ADD_REM: begin
          acc_q      <= acc_rem_d;
          ovf_q      <= ovf_d;
          dividend_q <= ovf_d ? '0 : acc_rem_d[WIDTH-1:0];
          state_q    <= S_RESULT;
        end
        S_RESULT: begin
          state_q <= S_IDLE;
        end
        S_ERROR: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dividend = dividend_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_RESULT) ||
                    (state_q == S_ERROR);
  assign error    = (state_q == S_ERROR) ||
                    ((state_q == S_RESULT) && ovf_q);

endmodule

// File: tb/tb_dividend_reconstructor.sv
// Scoreboard bench for dividend_reconstructor: expected results are queued
// at launch and popped when done pulses.
module tb_dividend_reconstructor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] quotient = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] remainder = '0;
  logic [W-1:0] dividend;
  logic         busy;
  logic         done;
  logic         error;

  int errors = 0;
  int checks = 0;

  logic [W:0] sb[$];
  logic [W:0] exp_v;

  dividend_reconstructor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .dividend  (dividend),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(int q, int d, int r);
    int p;
    if (d == 0 || r >= d) return {1'b1, {W{1'b0}}};
    p = q * d + r;
    if (p > (1 << W) - 1) return {1'b1, {W{1'b0}}};
    return {1'b0, p[W-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(int q, int d, int r);
    quotient  = q[W-1:0];
    divisor   = d[W-1:0];
    remainder = r[W-1:0];
  endtask

  // caller sits in IDLE; returns in cycle 1 (one edge after acceptance)
  task automatic launch(int q, int d, int r);
    set_ops(q, d, r);
    start = 1'b1;
    sb.push_back(model(q, d, r));
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(inout int cyc);
    while (done !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (dividend !== '0) begin
      errors++;
      $display("FAIL reset_dividend: got %0d want 0", dividend);
    end
    checks++;
    if ({busy, done, error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {busy, done, error});
    end
  endtask

  task automatic test_basic();
    int cyc = 1;
    launch(13, 7, 5);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 11) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 11", cyc);
    end
    exp_v = sb.pop_front();
    checks++;
    if ({error, dividend} !== exp_v) begin
      errors++;
      $display("FAIL basic_result: got err=%b div=%0d want err=%b div=%0d",
               error, dividend, exp_v[W], exp_v[W-1:0]);
    end
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL basic_after: got busy,done=%b want 00", {busy, done});
    end
  endtask

  task automatic test_invalid();
    int qs[3] = '{4, 3, 3};
    int ds[3] = '{0, 7, 7};
    int rs[3] = '{0, 7, 6};
    int ls[3] = '{2, 2, 11};
    for (int i = 0; i < 3; i++) begin
      int cyc = 1;
      launch(qs[i], ds[i], rs[i]);
      wait_done(cyc);
      checks++;
      if (cyc != ls[i]) begin
        errors++;
        $display("FAIL invalid_latency[%0d]: got %0d want %0d", i, cyc, ls[i]);
      end
      exp_v = sb.pop_front();
      checks++;
      if ({error, dividend} !== exp_v) begin
        errors++;
        $display("FAIL invalid_result[%0d]: got err=%b div=%0d want err=%b div=%0d",
                 i, error, dividend, exp_v[W], exp_v[W-1:0]);
      end
      step();
    end
  endtask

  task automatic test_boundary();
    int qs[7] = '{255, 255, 0, 0, 0, 0, 0};
    int ds[7] = '{1, 2, 9, 0, 0, 0, 0};
    int rs[7] = '{0, 1, 3, 0, 0, 0, 0};
    for (int i = 3; i < 7; i++) begin
      qs[i] = $urandom_range(0, 40);
      ds[i] = $urandom_range(1, 12);
      rs[i] = $urandom_range(0, ds[i] - 1);
    end
    for (int i = 0; i < 7; i++) begin
      int cyc = 1;
      launch(qs[i], ds[i], rs[i]);
      wait_done(cyc);
      checks++;
      if (cyc != 11) begin
        errors++;
        $display("FAIL bound_latency[%0d]: got %0d want 11", i, cyc);
      end
      exp_v = sb.pop_front();
      checks++;
      if ({error, dividend} !== exp_v) begin
        errors++;
        $display("FAIL bound_result[%0d] %0d*%0d+%0d: got err=%b div=%0d want err=%b div=%0d",
                 i, qs[i], ds[i], rs[i], error, dividend, exp_v[W], exp_v[W-1:0]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 1;
    launch(13, 7, 5);
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    checks++;
    if ({busy, done, dividend} !== {2'b00, {W{1'b0}}}) begin
      errors++;
      $display("FAIL midreset: got busy=%b done=%b div=%0d want 0 0 0",
               busy, done, dividend);
    end
    launch(10, 10, 9);
    wait_done(cyc);
    checks++;
    if (cyc != 11) begin
      errors++;
      $display("FAIL midreset_latency: got %0d want 11", cyc);
    end
    exp_v = sb.pop_front();
    checks++;
    if ({error, dividend} !== exp_v) begin
      errors++;
      $display("FAIL midreset_result: got err=%b div=%0d want err=%b div=%0d",
               error, dividend, exp_v[W], exp_v[W-1:0]);
    end
    step();
  endtask

  task automatic test_ignore_start();
    int cyc = 1;
    launch(13, 7, 5);
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc == 3 || cyc == 10) begin
        set_ops(200, 3, 1);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    if (done !== 1'b1) cyc = -1;
    checks++;
    if (cyc != 11) begin
      errors++;
      $display("FAIL ignore_latency: got %0d want 11", cyc);
    end
    exp_v = sb.pop_front();
    checks++;
    if ({error, dividend} !== exp_v) begin
      errors++;
      $display("FAIL ignore_result: got err=%b div=%0d want err=%b div=%0d",
               error, dividend, exp_v[W], exp_v[W-1:0]);
    end
    // start in the done cycle is dropped; next cycle it is taken
    set_ops(0, 9, 3);
    start = 1'b1;
    step();
    set_ops(3, 7, 6);
    sb.push_back(model(3, 7, 6));
    step();
    start = 1'b0;
    cyc = 1;
    wait_done(cyc);
    checks++;
    if (cyc != 11) begin
      errors++;
      $display("FAIL after_done_latency: got %0d want 11", cyc);
    end
    exp_v = sb.pop_front();
    checks++;
    if ({error, dividend} !== exp_v) begin
      errors++;
      $display("FAIL after_done_result: got err=%b div=%0d want err=%b div=%0d",
               error, dividend, exp_v[W], exp_v[W-1:0]);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int qs[3] = '{12, 30, 255};
    int ds[3] = '{11, 8, 1};
    int rs[3] = '{4, 7, 0};
    set_ops(qs[0], ds[0], rs[0]);
    sb.push_back(model(qs[0], ds[0], rs[0]));
    start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      int cyc = 1;
      if (i < 2) set_ops(qs[i+1], ds[i+1], rs[i+1]);
      else set_ops(5, 0, 0);
      wait_done(cyc);
      checks++;
      if (cyc != 11) begin
        errors++;
        $display("FAIL b2b_latency[%0d]: got %0d want 11", i, cyc);
      end
      exp_v = sb.pop_front();
      checks++;
      if ({error, dividend} !== exp_v) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got err=%b div=%0d want err=%b div=%0d",
                 i, error, dividend, exp_v[W], exp_v[W-1:0]);
      end
      if (i == 2) start = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle[%0d]: got busy=%b want 0", i, busy);
      end
      if (i < 2) begin
        sb.push_back(model(qs[i+1], ds[i+1], rs[i+1]));
        step();
      end
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_release: got busy=%b want 0", busy);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_basic();
    test_invalid();
    test_boundary();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
